// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity receive path (RX checker, TX and bench).
// Holds the FSM state encoding, the default word width and the parity reference function.
package serial_parity_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam int DATA_W_DEF = 8;

  function automatic logic parity_calc(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// 1-bit running XOR: clr wins, then load (first bit of a frame), then enable (accumulate).
// Latency 1 clk; no backpressure, updates on every qualified bit.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (load) begin
      acc <= bit_in;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// LSB-first serial frame receiver with parity check; word valid 1 clk after the parity bit.
// Serial side never stalls; a frame completing while the output is held is dropped (overrun). Stats: SERIAL_PARITY_STATS_EN.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin_valid,
  input  logic              sin_start,
  input  logic              sin_bit,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              par_err,
  output logic              overrun
`ifdef SERIAL_PARITY_STATS_EN
  ,
  output logic [15:0]       err_cnt,
  output logic [15:0]       frm_cnt
`endif
);

  localparam int CW = $clog2(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              acc;
  logic              bit_start;
  logic              bit_data;
  logic              bit_par;
  logic              out_free;
  logic              frame_err;

  // sin_start overrides the state: any start bit begins a fresh frame.
  assign bit_start = sin_valid && sin_start;
  assign bit_data  = sin_valid && !sin_start && (state == DATA);
  assign bit_par   = sin_valid && !sin_start && (state == PARITY);
  assign out_free  = !dout_valid || dout_ready;
  assign frame_err = acc ^ sin_bit ^ (ODD_PARITY != 0);

  parity_accum u_parity_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (bit_par),
    .load   (bit_start),
    .en     (bit_data),
    .bit_in (sin_bit),
    .acc    (acc)
  );

  // Shift in from the top: after DATA_W shifts bit 0 lands at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (bit_start) begin
      state <= DATA;
      cnt   <= CW'(1);
      shreg <= {sin_bit, shreg[DATA_W-1:1]};
    end else if (bit_data) begin
      shreg <= {sin_bit, shreg[DATA_W-1:1]};
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(DATA_W - 1)) begin
        state <= PARITY;
      end
    end else if (bit_par) begin
      state <= IDLE;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      par_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= bit_par && !out_free;
      if (bit_par && out_free) begin
        dout       <= shreg;
        par_err    <= frame_err;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_PARITY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else if (bit_par && out_free) begin
      if (frm_cnt != 16'hFFFF) frm_cnt <= frm_cnt + 16'd1;
      if (frame_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  // Statistics compiled out; the receive path above is unchanged.
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even-parity instance plus an odd-parity twin on the same stimulus.
module tb_serial_parity_checker;
  import serial_parity_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin_valid, sin_start, sin_bit, dout_ready;
  logic [W-1:0] dout_e, dout_o;
  logic         vld_e, vld_o, perr_e, perr_o, ovr_e, ovr_o;
`ifdef SERIAL_PARITY_STATS_EN
  logic [15:0]  err_cnt_e, frm_cnt_e, err_cnt_o, frm_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(W), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_start(sin_start), .sin_bit(sin_bit),
    .dout(dout_e), .dout_valid(vld_e), .dout_ready(dout_ready), .par_err(perr_e), .overrun(ovr_e)
`ifdef SERIAL_PARITY_STATS_EN
    , .err_cnt(err_cnt_e), .frm_cnt(frm_cnt_e)
`endif
  );

  serial_parity_checker #(.DATA_W(W), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_start(sin_start), .sin_bit(sin_bit),
    .dout(dout_o), .dout_valid(vld_o), .dout_ready(dout_ready), .par_err(perr_o), .overrun(ovr_o)
`ifdef SERIAL_PARITY_STATS_EN
    , .err_cnt(err_cnt_o), .frm_cnt(frm_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one bit across the next posedge and returns at the following negedge.
  task automatic send_bit(input logic start, input logic b);
    sin_valid = 1'b1;
    sin_start = start;
    sin_bit   = b;
    @(negedge clk);
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_data(input logic [W-1:0] d, input int nbits, input int gmax);
    for (int i = 0; i < nbits; i++) begin
      if (gmax > 0) idle($urandom_range(0, gmax));
      send_bit(i == 0, d[i]);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic pbit, input int gmax);
    send_data(d, W, gmax);
    if (gmax > 0) idle($urandom_range(0, gmax));
    send_bit(1'b0, pbit);
  endtask

  initial begin
    rst = 1'b1; sin_valid = 1'b0; sin_start = 1'b0; sin_bit = 1'b0; dout_ready = 1'b1;
    idle(2);
    check("rst_dout", 32'(dout_e), 32'h0);
    check("rst_valid", 32'(vld_e), 32'h0);
    check("rst_perr", 32'(perr_e), 32'h0);
    check("rst_ovr", 32'(ovr_e), 32'h0);
`ifdef SERIAL_PARITY_STATS_EN
    check("rst_frm_cnt", 32'(frm_cnt_e), 32'h0);
    check("rst_err_cnt", 32'(err_cnt_e), 32'h0);
`endif
    rst = 1'b0;
    idle(1);

    // 0xA5: four ones, even parity bit 0
    send_data(8'hA5, W, 0);
    check("a5_valid_before_par", 32'(vld_e), 32'h0);
    send_bit(1'b0, parity_calc(32'h000000A5, 1'b0));
    check("a5_valid", 32'(vld_e), 32'h1);
    check("a5_dout", 32'(dout_e), 32'hA5);
    check("a5_perr", 32'(perr_e), 32'h0);
    check("a5_perr_odd", 32'(perr_o), 32'h1);
    idle(1);
    check("a5_valid_drop", 32'(vld_e), 32'h0);
    check("a5_dout_hold", 32'(dout_e), 32'hA5);

    // 0x3C with a wrong even parity bit
    send_frame(8'h3C, 1'b1, 0);
    check("3c_dout", 32'(dout_e), 32'h3C);
    check("3c_perr", 32'(perr_e), 32'h1);
    check("3c_perr_odd", 32'(perr_o), 32'h0);
    idle(1);
    check("3c_perr_hold", 32'(perr_e), 32'h1);

    // Backpressure: second frame dropped with a one-cycle overrun pulse
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 0);
    check("bp_11_valid", 32'(vld_e), 32'h1);
    check("bp_11_perr", 32'(perr_e), 32'h0);
    check("bp_11_ovr", 32'(ovr_e), 32'h0);
    send_frame(8'h22, 1'b0, 0);
    check("bp_ovr_pulse", 32'(ovr_e), 32'h1);
    check("bp_dout_kept", 32'(dout_e), 32'h11);
    check("bp_ovr_odd", 32'(ovr_o), 32'h1);
    idle(1);
    check("bp_ovr_one_cycle", 32'(ovr_e), 32'h0);
    check("bp_valid_held", 32'(vld_e), 32'h1);
    dout_ready = 1'b1;
    idle(1);
    check("bp_valid_drop", 32'(vld_e), 32'h0);

    // Parity bit arrives in the same cycle the held word is accepted
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 0);
    send_data(8'h22, W, 0);
    dout_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    check("same_cyc_dout", 32'(dout_e), 32'h22);
    check("same_cyc_valid", 32'(vld_e), 32'h1);
    check("same_cyc_ovr", 32'(ovr_e), 32'h0);
    idle(1);
    check("same_cyc_drop", 32'(vld_e), 32'h0);

    // Abort: 4 bits of 0xFF, then a fresh frame 0x81
    send_data(8'hFF, 4, 0);
    send_data(8'h81, W, 0);
    check("abort_no_valid", 32'(vld_e), 32'h0);
    send_bit(1'b0, 1'b0);
    check("abort_dout", 32'(dout_e), 32'h81);
    check("abort_perr", 32'(perr_e), 32'h0);
    idle(1);

    send_data(8'hFF, 4, 3);
    send_frame(8'h81, 1'b0, 3);
    check("gap_valid", 32'(vld_e), 32'h1);
    check("gap_dout", 32'(dout_e), 32'h81);
    check("gap_perr", 32'(perr_e), 32'h0);
    idle(1);

`ifdef SERIAL_PARITY_STATS_EN
    // Loaded so far: A5, 3C(bad), 11, 11, 22, 81, 81; one dropped 22
    check("stats_frm_cnt", 32'(frm_cnt_e), 32'd7);
    check("stats_err_cnt", 32'(err_cnt_e), 32'd1);
`endif

    // Reset mid-frame with a held word
    dout_ready = 1'b0;
    send_frame(8'h77, 1'b0, 0);
    send_data(8'h12, 6, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(vld_e), 32'h0);
    check("arst_dout", 32'(dout_e), 32'h0);
    check("arst_perr", 32'(perr_e), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dout_ready = 1'b1;
    idle(1);
    send_frame(8'h5A, parity_calc(32'h0000005A, 1'b0), 0);
    check("post_rst_valid", 32'(vld_e), 32'h1);
    check("post_rst_dout", 32'(dout_e), 32'h5A);
    check("post_rst_perr", 32'(perr_e), 32'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
